// File: rtl/instr_cache_fetch_pkg.sv
// Shared types, default parameters and address-split helpers for the
// instruction cache fetch front end.
package instr_cache_fetch_pkg;

   localparam int DEF_ADDR_W         = 32;
   localparam int DEF_DATA_W         = 32;
   localparam int DEF_SETS           = 16;
   localparam int DEF_WAYS           = 2;
   localparam int DEF_WORDS_PER_LINE = 2;
   localparam int DEF_CNT_W          = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_INSTALL
   } fetch_state_e;

   // Index width that never collapses to zero bits, so single-entry
   // selectors still declare as legal vectors.
   function automatic int sel_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int off_bits(input int words_per_line);
      return $clog2(words_per_line) + 2;
   endfunction

   function automatic int idx_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_bits(input int addr_w, input int words_per_line, input int sets);
      return addr_w - off_bits(words_per_line) - idx_bits(sets);
   endfunction

endpackage

// File: rtl/instr_cache_fetch_if.sv
// Fetch-side and memory-side signals of the instruction cache; the cache
// uses the slave modport, the IF stage / memory model uses master.
interface instr_cache_fetch_if
   import instr_cache_fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
);
   logic [ADDR_W-1:0] PC_F;
   logic              fetch_req;
   logic              flush;
   logic [DATA_W-1:0] Instr_F;
   logic              instr_valid;
   logic              stall_f;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   modport master (
      output PC_F, fetch_req, flush, mem_rvalid, mem_rdata,
      input  Instr_F, instr_valid, stall_f, mem_req, mem_addr, hit_cnt, miss_cnt
   );

   modport slave (
      input  PC_F, fetch_req, flush, mem_rvalid, mem_rdata,
      output Instr_F, instr_valid, stall_f, mem_req, mem_addr, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/instr_cache_fetch_icache_way.sv
// One cache way: per-set valid/tag/line storage with a combinational
// lookup port and a whole-line write port.
module icache_way
   import instr_cache_fetch_pkg::*;
#(
   parameter int SETS   = DEF_SETS,
   parameter int WORDS  = DEF_WORDS_PER_LINE,
   parameter int TAG_W  = 27,
   parameter int DATA_W = DEF_DATA_W,
   localparam int IDX_W  = idx_bits(SETS),
   localparam int WSEL_W = sel_bits(WORDS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         inval_all,
   input  logic [IDX_W-1:0]             rd_idx,
   input  logic [TAG_W-1:0]             rd_tag,
   input  logic [WSEL_W-1:0]            rd_word,
   output logic                         rd_valid,
   output logic                         rd_hit,
   output logic [DATA_W-1:0]            rd_data,
   input  logic                         wr_en,
   input  logic [IDX_W-1:0]             wr_idx,
   input  logic [TAG_W-1:0]             wr_tag,
   input  logic [WORDS-1:0][DATA_W-1:0] wr_line
);

   logic [SETS-1:0]              valid_q;
   logic [TAG_W-1:0]             tag_q  [SETS];
   logic [WORDS-1:0][DATA_W-1:0] data_q [SETS];

   always_ff @(posedge clk) begin
      if (reset || inval_all) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag and data need no reset: they are never trusted without valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_line;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_hit   = rd_valid && (tag_q[rd_idx] == rd_tag);
   assign rd_data  = data_q[rd_idx][rd_word];

endmodule

// File: rtl/instr_cache_fetch.sv
// Set-associative instruction cache front end: zero-cycle hit lookup,
// multi-beat refill FSM, victim selection and hit/miss counters.
//
// state      | meaning
// ST_IDLE    | look up PC_F; a miss latches line base and victim way
// ST_FILL    | request line beats from memory into the line buffer
// ST_INSTALL | write the buffered line into the victim way unless aborted
module instr_cache_fetch
   import instr_cache_fetch_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int SETS           = DEF_SETS,
   parameter int WAYS           = DEF_WAYS,
   parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   instr_cache_fetch_if.slave bus
);

   localparam int OFF    = off_bits(WORDS_PER_LINE);
   localparam int IDX    = idx_bits(SETS);
   localparam int TAG    = tag_bits(ADDR_W, WORDS_PER_LINE, SETS);
   localparam int WSEL_W = sel_bits(WORDS_PER_LINE);
   localparam int WAY_W  = sel_bits(WAYS);
   localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS_PER_LINE - 1);

   fetch_state_e                          state_q, state_d;
   logic [ADDR_W-1:0]                     base_q;
   logic [WAY_W-1:0]                      victim_q, victim_d;
   logic [WSEL_W-1:0]                     beat_q;
   logic                                  abort_q;
   logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_q;
   logic [WAY_W-1:0]                      rr_q [SETS];
   logic [CNT_W-1:0]                      hit_cnt_q, miss_cnt_q;

   logic [IDX-1:0]    pc_idx, base_idx;
   logic [TAG-1:0]    pc_tag, base_tag;
   logic [WSEL_W-1:0] pc_word;
   logic [WAYS-1:0]   way_hit, way_valid;
   logic [DATA_W-1:0] way_data [WAYS];
   logic              any_hit, hit, miss, install_we, victim_found;
   logic [DATA_W-1:0] hit_data;

   assign pc_idx   = bus.PC_F[OFF +: IDX];
   assign pc_tag   = bus.PC_F[ADDR_W-1 -: TAG];
   assign pc_word  = (WORDS_PER_LINE > 1) ? bus.PC_F[2 +: WSEL_W] : '0;
   assign base_idx = base_q[OFF +: IDX];
   assign base_tag = base_q[ADDR_W-1 -: TAG];

   // A flush landing on the install cycle also suppresses the write.
   assign install_we = (state_q == ST_INSTALL) && !abort_q && !bus.flush;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way #(
         .SETS(SETS), .WORDS(WORDS_PER_LINE), .TAG_W(TAG), .DATA_W(DATA_W)
      ) u_way (
         .clk(clk),           .reset(reset),      .inval_all(bus.flush),
         .rd_idx(pc_idx),     .rd_tag(pc_tag),    .rd_word(pc_word),
         .rd_valid(way_valid[w]), .rd_hit(way_hit[w]), .rd_data(way_data[w]),
         .wr_en(install_we && (victim_q == WAY_W'(w))),
         .wr_idx(base_idx),   .wr_tag(base_tag),  .wr_line(line_q)
      );
   end

   always_comb begin
      any_hit      = 1'b0;
      hit_data     = '0;
      victim_found = 1'b0;
      victim_d     = rr_q[pc_idx];
      for (int w = 0; w < WAYS; w++) begin
         if (way_hit[w]) begin
            any_hit  = 1'b1;
            hit_data = way_data[w];
         end
         if (!victim_found && !way_valid[w]) begin
            victim_found = 1'b1;
            victim_d     = WAY_W'(w);
         end
      end
   end

   assign hit  = (state_q == ST_IDLE) && bus.fetch_req && !bus.flush && any_hit;
   assign miss = (state_q == ST_IDLE) && bus.fetch_req && !bus.flush && !any_hit;

   always_comb begin
      state_d         = state_q;
      bus.instr_valid = hit;
      bus.Instr_F     = hit ? hit_data : '0;
      bus.stall_f     = bus.fetch_req && !hit;
      bus.mem_req     = 1'b0;
      bus.mem_addr    = '0;
      case (state_q)
         ST_IDLE: begin
            if (miss) state_d = ST_FILL;
         end
         ST_FILL: begin
            bus.stall_f  = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = base_q + (ADDR_W'(beat_q) << 2);
            if (bus.mem_rvalid && (beat_q == LAST_BEAT)) state_d = ST_INSTALL;
         end
         ST_INSTALL: begin
            bus.stall_f = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         victim_q   <= '0;
         beat_q     <= '0;
         abort_q    <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else begin
         state_q <= state_d;
         if (hit) hit_cnt_q <= hit_cnt_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (miss) begin
                  base_q     <= {bus.PC_F[ADDR_W-1:OFF], {OFF{1'b0}}};
                  victim_q   <= victim_d;
                  miss_cnt_q <= miss_cnt_q + 1'b1;
                  abort_q    <= 1'b0;
               end
            end
            ST_FILL: begin
               if (bus.flush) abort_q <= 1'b1;
               if (bus.mem_rvalid) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            end
            ST_INSTALL: begin
               if (install_we) rr_q[base_idx] <= rr_q[base_idx] + 1'b1;
               abort_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == ST_FILL) && bus.mem_rvalid) line_q[beat_q] <= bus.mem_rdata;
   end

   assign bus.hit_cnt  = hit_cnt_q;
   assign bus.miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_instr_cache_fetch.sv
// Scoreboard bench for instr_cache_fetch: directed scenarios followed by
// random fetches, checked against a line-level cache model.
module tb_instr_cache_fetch;
   import instr_cache_fetch_pkg::*;

   localparam int SETS  = 16;
   localparam int WAYS  = 2;
   localparam int WORDS = 2;
   localparam int LB    = WORDS * 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic stray = 1'b0;
   int   wait_mode = 0;
   logic [31:0] exp_base = '0;
   int   compared = 0;
   int   mismatched = 0;
   exp_t sb_q[$];

   bit          m_valid [SETS][WAYS];
   logic [31:0] m_line  [SETS][WAYS];
   int          m_rr    [SETS];
   int          m_hits, m_misses;

   instr_cache_fetch_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) bus ();

   instr_cache_fetch #(
      .ADDR_W(32), .DATA_W(32), .SETS(SETS), .WAYS(WAYS),
      .WORDS_PER_LINE(WORDS), .CNT_W(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0001) ^ 32'hAAAA_5555;
   endfunction

   function automatic logic [31:0] line_base(input logic [31:0] pc);
      return (pc / LB) * LB;
   endfunction

   function automatic int pick_wait();
      return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
   endfunction

   // Reference model: a set holds up to WAYS line numbers.
   function automatic bit model_hit(input logic [31:0] pc);
      logic [31:0] line;
      int s;
      line = pc / LB;
      s = int'(line % SETS);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_line[s][w] == line) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_install(input logic [31:0] pc);
      logic [31:0] line;
      int s, v;
      line = pc / LB;
      s = int'(line % SETS);
      v = -1;
      for (int w = 0; w < WAYS; w++)
         if (!m_valid[s][w] && v < 0) v = w;
      if (v < 0) v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
      m_valid[s][v] = 1'b1;
      m_line[s][v]  = line;
   endtask

   task automatic model_flush();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
   endtask

   task automatic model_reset();
      model_flush();
      for (int s = 0; s < SETS; s++) m_rr[s] = 0;
      m_hits = 0;
      m_misses = 0;
   endtask

   // Memory responder: fixed or random wait states before each beat.
   initial begin
      int beat, wl;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      beat = 0;
      wl = 0;
      forever begin
         @(posedge clk); #1;
         if (bus.mem_rvalid) begin
            beat++;
            wl = pick_wait();
         end
         if (reset || !bus.mem_req) begin
            beat = 0;
            wl = pick_wait();
            bus.mem_rvalid = stray;
            bus.mem_rdata  = stray ? 32'hDEAD_BEEF : 32'h0;
         end else begin
            check("mem_addr", bus.mem_addr, exp_base + 32'(4 * beat));
            if (wl > 0) begin
               bus.mem_rvalid = 1'b0;
               wl--;
            end else begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = mem_word(bus.mem_addr);
            end
         end
      end
   end

   // Monitor: every valid instruction is matched against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.instr_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_valid", bus.Instr_F, 32'h0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("instr", bus.Instr_F, e.data);
            end
         end else begin
            check("instr_zero", bus.Instr_F, 32'h0);
         end
      end
   end

   task automatic do_fetch(input logic [31:0] pc, input bit ff);
      bit   exp_hit, eff;
      int   cycles, fills;
      exp_t e;
      exp_hit = model_hit(pc);
      eff = ff && !exp_hit;
      bus.PC_F = pc;
      bus.fetch_req = 1'b1;
      e.pc = pc;
      e.data = mem_word(pc);
      sb_q.push_back(e);
      m_hits++;
      if (!exp_hit) begin
         m_misses++;
         exp_base = line_base(pc);
         if (eff) begin
            m_misses++;
            model_flush();
         end
         model_install(pc);
      end
      cycles = 0;
      while (1) begin
         @(negedge clk);
         if (bus.instr_valid) break;
         cycles++;
         if (cycles > 400) begin
            check("fetch_timeout", cycles, 400);
            break;
         end
         @(posedge clk); #1;
         bus.flush = eff && (cycles == 1);
      end
      bus.flush = 1'b0;
      if (exp_hit) begin
         check("hit_latency", cycles, 0);
      end else if (wait_mode >= 0) begin
         fills = eff ? 2 : 1;
         check("miss_latency", cycles, fills * (2 + WORDS * (wait_mode + 1)));
      end else begin
         check("miss_latency_min", cycles >= 2 + WORDS, 1);
      end
      @(posedge clk); #1;
      bus.fetch_req = 1'b0;
      check("hit_cnt", bus.hit_cnt, m_hits);
      check("miss_cnt", bus.miss_cnt, m_misses);
   endtask

   task automatic flush_idle(input bit f);
      bus.flush = 1'b1;
      bus.fetch_req = f;
      bus.PC_F = 32'h100;
      @(negedge clk);
      check("flush_stall", bus.stall_f, f);
      check("flush_no_valid", bus.instr_valid, 1'b0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.fetch_req = 1'b0;
      model_flush();
      check("flush_miss_cnt", bus.miss_cnt, m_misses);
   endtask

   task automatic reset_mid_fill();
      wait_mode = 0;
      flush_idle(1'b0);
      bus.PC_F = 32'h608;
      bus.fetch_req = 1'b1;
      exp_base = line_base(32'h608);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      bus.fetch_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_hit_cnt", bus.hit_cnt, 32'h0);
      check("rst_miss_cnt", bus.miss_cnt, 32'h0);
      @(negedge clk) stray = 1'b1;
      @(negedge clk) stray = 1'b0;
      @(posedge clk); #1;
      check("stray_mem_req", bus.mem_req, 1'b0);
      check("stray_miss_cnt", bus.miss_cnt, 32'h0);
      do_fetch(32'h60C, 1'b0);
   endtask

   function automatic logic [31:0] rand_pc();
      return $urandom_range(0, 3) * SETS * LB + $urandom_range(0, 3) * LB
             + $urandom_range(0, WORDS - 1) * 4;
   endfunction

   initial begin
      int gap;
      reset = 1'b1;
      bus.PC_F = '0;
      bus.fetch_req = 1'b0;
      bus.flush = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_mem_req", bus.mem_req, 1'b0);
      check("reset_stall", bus.stall_f, 1'b0);
      check("reset_valid", bus.instr_valid, 1'b0);
      check("reset_hit_cnt", bus.hit_cnt, 32'h0);
      check("reset_miss_cnt", bus.miss_cnt, 32'h0);
      @(posedge clk); #1;

      wait_mode = 0;
      do_fetch(32'h100, 1'b0);
      do_fetch(32'h104, 1'b0);
      do_fetch(32'h180, 1'b0);
      do_fetch(32'h200, 1'b0);
      do_fetch(32'h180, 1'b0);
      do_fetch(32'h100, 1'b0);

      wait_mode = 3;
      flush_idle(1'b1);
      do_fetch(32'h300, 1'b0);
      do_fetch(32'h304, 1'b0);

      wait_mode = 0;
      flush_idle(1'b0);
      do_fetch(32'h500, 1'b0);
      do_fetch(32'h400, 1'b1);
      do_fetch(32'h404, 1'b0);
      do_fetch(32'h500, 1'b0);

      reset_mid_fill();

      wait_mode = -1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 99) < 8) flush_idle(1'($urandom_range(0, 1)));
         else do_fetch(rand_pc(), $urandom_range(0, 99) < 10);
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge clk); #1;
         end
      end

      repeat (5) @(posedge clk);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
